// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank driver: {j,k} command codes and FSM states.
package jk_pkg;

  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] RESET  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK
  } state_t;

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: picks the {j,k} command that moves q to target.
// Optional macro JK_TOGGLE_CMD_EN: bits that must change get TOGGLE instead of SET/RESET.
module jk_excite
  import jk_pkg::*;
(
  input  logic q,
  input  logic target,
  input  logic mask,
  output logic j,
  output logic k
);

  logic [1:0] cmd;

  // Hold unless the bit is selected and differs from its target.
  always_comb begin
    cmd = HOLD;
    if (mask && (q != target)) begin
`ifdef JK_TOGGLE_CMD_EN
      cmd = TOGGLE;
`else
      cmd = target ? SET : RESET;
`endif
    end
  end

  assign {j, k} = cmd;

endmodule

// File: rtl/jk_bank_driver.sv
// Command-side controller for a bank of WIDTH JK flip-flops: accepts a target/mask,
// drives one command cycle, checks the bank's q and retries up to MAX_RETRY times.
// Optional macro JK_TOGGLE_CMD_EN (handled in jk_excite) selects TOGGLE commands.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] req_mask,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] tgt_q, msk_q, tgt_nx, msk_nx;
  logic [WIDTH-1:0] j_nx, k_nx;
  logic [WIDTH-1:0] ex_tgt, ex_msk, ex_j, ex_k;
  logic [CNT_W-1:0] retry_q, retry_nx;
  logic             done_nx, err_nx;

  // In IDLE the commands come from the incoming request; on a retry from the latched one.
  assign ex_tgt = (state == IDLE) ? req_target : tgt_q;
  assign ex_msk = (state == IDLE) ? req_mask   : msk_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_excite
    jk_excite u_excite (
      .q      (q_fb[i]),
      .target (ex_tgt[i]),
      .mask   (ex_msk[i]),
      .j      (ex_j[i]),
      .k      (ex_k[i])
    );
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Next-state and next-output decode; commands default to HOLD every cycle.
  always_comb begin
    state_nx = state;
    tgt_nx   = tgt_q;
    msk_nx   = msk_q;
    retry_nx = retry_q;
    j_nx     = '0;
    k_nx     = '0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          tgt_nx   = req_target;
          msk_nx   = req_mask;
          j_nx     = ex_j;
          k_nx     = ex_k;
          retry_nx = '0;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        state_nx = CHECK;
      end
      CHECK: begin
        if ((q_fb & msk_q) == (tgt_q & msk_q)) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else if (retry_q < CNT_W'(MAX_RETRY)) begin
          retry_nx = retry_q + CNT_W'(1);
          j_nx     = ex_j;
          k_nx     = ex_k;
          state_nx = DRIVE;
        end else begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Datapath registers: commands, status pulses, latched request and retry count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j       <= '0;
      k       <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      tgt_q   <= '0;
      msk_q   <= '0;
      retry_q <= '0;
    end else begin
      j       <= j_nx;
      k       <= k_nx;
      done    <= done_nx;
      err     <= err_nx;
      tgt_q   <= tgt_nx;
      msk_q   <= msk_nx;
      retry_q <= retry_nx;
    end
  end

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Command-side controller for a bank of WIDTH JK flip-flops (j/k inputs, q outputs, common clock).
- Accepts a target pattern and bit mask over a valid/ready handshake.
- Computes per-bit {j,k} commands from JK excitation rules, using the bank's live q feedback, and drives one command cycle.
- Checks the resulting q, retries on mismatch, and reports done or err.

Parameters:
- WIDTH, 8, number of JK flip-flops in the driven bank.
- MAX_RETRY, 3, extra drive attempts after the first before err; total drives = 1 + MAX_RETRY.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_target  input  WIDTH  desired q value.
- req_mask  input  WIDTH  1 = bit is updated; 0 = bit is held and ignored in the compare.
- q_fb  input  WIDTH  q outputs of the JK bank.
- j  output  WIDTH  registered J commands to the bank.
- k  output  WIDTH  registered K commands to the bank.
- busy  output  1  high in DRIVE and CHECK.
- done  output  1  one-cycle pulse: masked q matched the target.
- err  output  1  one-cycle pulse: retries exhausted without a match.

Behaviour:
- Reset: async assert forces state=IDLE, j=0, k=0, done=0, err=0, retry count=0, latched target/mask=0. After reset, req_ready=1 and busy=0. Reset mid-operation aborts immediately; the bank sees hold (00) from the same instant.
- Command encoding {j,k}: HOLD=00, RESET=01, SET=10, TOGGLE=11.
- Excitation per masked bit, from q_fb and target:
  - 0->0: 00.
  - 0->1: 10 (SET).
  - 1->0: 01 (RESET).
  - 1->1: 00.
  - Unmasked bits always 00.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready:
    - latch target and mask;
    - register j/k from the current q_fb;
    - retry count=0;
    - go to DRIVE.
  - DRIVE (1 cycle): j/k are on the outputs; the bank updates at the end-of-cycle edge. Go to CHECK. On that edge j,k<=0.
  - CHECK (1 cycle): compare (q_fb & mask) with (target & mask).
    - Match: done<=1, go to IDLE.
    - Mismatch and retry count < MAX_RETRY: increment retry count, re-register j/k from the current q_fb, go to DRIVE.
    - Otherwise: err<=1, go to IDLE.
- done/err are high during the first IDLE cycle after CHECK and clear on the next edge. req_ready is already 1 in that cycle, so back-to-back requests are allowed.
- Latency: accept at edge E, j/k valid during cycle E..E+1, done/err high in cycle E+2..E+3 when no retry. Each retry adds 2 cycles.
- req_ready=0 in DRIVE and CHECK. req_valid is ignored there and never lost by the controller; the requester holds it.
- Mask=0: no shortcut. j=k=0 for the DRIVE cycle, then done after normal latency.
- done and err are never high together. j and k are never both 1 unless the optional feature is enabled.

Optional Feature:
- Macro JK_TOGGLE_CMD_EN.
- Defined: masked bits that must change (0->1 or 1->0) get TOGGLE (11) instead of SET/RESET. Retries still recompute from live q_fb.
- Undefined: SET/RESET only, and j&k == 0 always.

Decomposition:
- Package jk_pkg holds:
  - localparams HOLD/RESET/SET/TOGGLE (2-bit {j,k});
  - state enum IDLE/DRIVE/CHECK.
- Sub-module jk_excite: per-bit combinational function (q, target, mask -> j, k), instantiated WIDTH times via generate. It owns the JK_TOGGLE_CMD_EN choice.

Test Plan:
- Reset:
  - rst=1 asynchronously between edges -> j=0, k=0, done=0, err=0 immediately.
  - After release -> req_ready=1, busy=0.
- Basic set (behavioural JK bank model, q=0x00): request target 0xA5, mask 0xFF -> DRIVE j=0xA5, k=0x00. Bank q=0xA5, done pulse 2 cycles after accept, err=0.
- Mixed (q=0xF0): target 0x0F, mask 0x3C -> j=0x0C, k=0x30, final q=0xCC, done=1.
- Stuck bank (q_fb forced 0x00): target 0x01, mask 0x01 -> 4 DRIVE cycles each with j=0x01, then err pulse, done=0, 8 cycles after accept.
- Back-to-back: req_valid held with a second request during busy -> second request accepted in the done cycle, and req_ready is never high in DRIVE/CHECK.
- Abort: rst pulsed during DRIVE -> j/k cleared at once, state IDLE, no done/err. With JK_TOGGLE_CMD_EN, the mixed case yields j=k=0x3C.
